// File: rtl/bst_game_ctrl.sv
// Purpose: sequences key load, one-cycle settle and level-order guess play for the BST mini-game.
// Latency: result pulses, score, lives and state change one cycle after the key/guess/timeout cycle.
// Backpressure: key_ready is high only in LOAD; guesses are never stalled, one per cycle in PLAY.
module bst_game_ctrl #(
  parameter int LIVES       = 3,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic        dup_err,
  output logic [55:0] keys_out,
  output logic        core_valid,
  output logic [2:0]  core_index,
  input  logic [7:0]  core_key,
  input  logic [7:0]  guess,
  input  logic        guess_valid,
  output logic        hit,
  output logic        miss,
  output logic        timeout,
  output logic [2:0]  score,
  output logic [1:0]  lives,
  output logic [2:0]  state,
  output logic        done,
  output logic        win
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_PLAY   = 3'd3,
    S_WIN    = 3'd4,
    S_LOSE   = 3'd5
  } state_t;

  localparam int              TW         = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   T_LAST     = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);

  state_t        st_q;
  logic [7:0]    slot [7];
  logic [2:0]    load_cnt;
  logic [TW-1:0] timer;
  logic          is_dup;

  // Status decodes straight from the state register.
  assign state     = st_q;
  assign key_ready = (st_q == S_LOAD);
  assign done      = (st_q == S_WIN) || (st_q == S_LOSE);
  assign win       = (st_q == S_WIN);

  // Pack stored slots for the core, k0 in the low byte.
  always_comb begin
    keys_out = '0;
    for (int i = 0; i < 7; i++) keys_out[8*i +: 8] = slot[i];
  end

  // Duplicate check only looks at slots already filled in this load.
  always_comb begin
    is_dup = 1'b0;
    for (int i = 0; i < 7; i++)
      if ((3'(i) < load_cnt) && (slot[i] == key_in)) is_dup = 1'b1;
  end

  // Game FSM: start restarts from any state and overrides same-cycle keys/guesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= S_IDLE;
      for (int i = 0; i < 7; i++) slot[i] <= 8'd0;
      load_cnt   <= 3'd0;
      timer      <= '0;
      dup_err    <= 1'b0;
      core_valid <= 1'b0;
      core_index <= 3'd0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      timeout    <= 1'b0;
      score      <= 3'd0;
      lives      <= LIVES_INIT;
    end else begin
      dup_err <= 1'b0;
      hit     <= 1'b0;
      miss    <= 1'b0;
      timeout <= 1'b0;
      if (start) begin
        st_q       <= S_LOAD;
        for (int i = 0; i < 7; i++) slot[i] <= 8'd0;
        load_cnt   <= 3'd0;
        timer      <= '0;
        core_valid <= 1'b0;
        core_index <= 3'd0;
        score      <= 3'd0;
        lives      <= LIVES_INIT;
      end else begin
        case (st_q)
          S_LOAD: begin
            if (key_valid) begin
              if (is_dup) begin
                dup_err <= 1'b1;
              end else begin
                for (int i = 0; i < 7; i++)
                  if (3'(i) == load_cnt) slot[i] <= key_in;
                load_cnt <= load_cnt + 3'd1;
                if (load_cnt == 3'd6) st_q <= S_SETTLE;
              end
            end
          end
          S_SETTLE: begin
            core_valid <= 1'b1;
            core_index <= score;
            timer      <= '0;
            st_q       <= S_PLAY;
          end
          S_PLAY: begin
            if (guess_valid) begin
              timer <= '0;
              if (guess == core_key) begin
                hit   <= 1'b1;
                score <= score + 3'd1;
                // On the final hit the index stays on the last valid node (RR).
                if (score == 3'd6) st_q <= S_WIN;
                else               core_index <= score + 3'd1;
              end else begin
                miss  <= 1'b1;
                lives <= lives - 2'd1;
                if (lives == 2'd1) st_q <= S_LOSE;
              end
            end else if (timer == T_LAST) begin
              timer   <= '0;
              timeout <= 1'b1;
              miss    <= 1'b1;
              lives   <= lives - 2'd1;
              if (lives == 2'd1) st_q <= S_LOSE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bst_game_ctrl.sv
// Purpose: directed, table-driven check of bst_game_ctrl with a behavioural BST core model.
// Latency: inputs driven at negedge, outputs checked at the following negedge.
// Backpressure: none; key and guess streams are driven back-to-back.
module tb_bst_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  key_in;
  logic        key_valid;
  logic        key_ready;
  logic        dup_err;
  logic [55:0] keys_out;
  logic        core_valid;
  logic [2:0]  core_index;
  logic [7:0]  core_key;
  logic [7:0]  guess;
  logic        guess_valid;
  logic        hit, miss, timeout;
  logic [2:0]  score;
  logic [1:0]  lives;
  logic [2:0]  state;
  logic        done, win;

  int tests  = 0;
  int failed = 0;

  bst_game_ctrl #(.LIVES(3), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready), .dup_err(dup_err),
    .keys_out(keys_out), .core_valid(core_valid), .core_index(core_index), .core_key(core_key),
    .guess(guess), .guess_valid(guess_valid),
    .hit(hit), .miss(miss), .timeout(timeout), .score(score), .lives(lives),
    .state(state), .done(done), .win(win)
  );

  always #5 clk = ~clk;

  // Behavioural core: balanced BST built from the sorted keys, read in level order.
  function automatic logic [7:0] core_model(input logic [55:0] ko, input logic [2:0] idx);
    logic [7:0] s [7];
    logic [7:0] t;
    for (int i = 0; i < 7; i++) s[i] = ko[8*i +: 8];
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    case (idx)
      3'd0: return s[3];
      3'd1: return s[1];
      3'd2: return s[5];
      3'd3: return s[0];
      3'd4: return s[2];
      3'd5: return s[4];
      3'd6: return s[6];
      default: return 8'd0;
    endcase
  endfunction

  always_comb core_key = core_model(keys_out, core_index);

  typedef struct {
    logic       st;
    logic       kv;
    logic [7:0] k;
    logic       gv;
    logic [7:0] g;
    logic [2:0] e_state;
    logic       e_hit;
    logic       e_miss;
    logic       e_dup;
    logic [2:0] e_score;
    logic [1:0] e_lives;
    logic       e_cv;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic st, input logic kv, input logic [7:0] k,
                     input logic gv, input logic [7:0] g,
                     input logic [2:0] es, input logic eh, input logic em, input logic ed,
                     input logic [2:0] esc, input logic [1:0] el, input logic ecv);
    vec_t v;
    v.st = st; v.kv = kv; v.k = k; v.gv = gv; v.g = g;
    v.e_state = es; v.e_hit = eh; v.e_miss = em; v.e_dup = ed;
    v.e_score = esc; v.e_lives = el; v.e_cv = ecv;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    start = 1'b0; key_valid = 1'b0; guess_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [12:0] got, exp;
    for (int i = lo; i <= hi; i++) begin
      start = tbl[i].st; key_valid = tbl[i].kv; key_in = tbl[i].k;
      guess_valid = tbl[i].gv; guess = tbl[i].g;
      step();
      got = {state, hit, miss, timeout, dup_err, score, lives, core_valid};
      exp = {tbl[i].e_state, tbl[i].e_hit, tbl[i].e_miss, 1'b0, tbl[i].e_dup,
             tbl[i].e_score, tbl[i].e_lives, tbl[i].e_cv};
      chk($sformatf("vec[%0d]", i), 64'(got), 64'(exp));
    end
    idle_in();
  endtask

  // Start, load seven keys back-to-back, then pass through SETTLE into PLAY.
  task automatic load7(input logic [55:0] ks, output int dups);
    dups = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      key_valid = 1'b1; key_in = ks[8*i +: 8];
      step();
      if (dup_err) dups++;
    end
    key_valid = 1'b0;
    step();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_keys"}, 64'(keys_out), 64'd0);
    chk({tag, "_flags"}, 64'({key_ready, dup_err, core_valid, hit, miss, timeout, done, win}), 64'd0);
    chk({tag, "_idx"}, 64'(core_index), 64'd0);
    chk({tag, "_score_lives"}, 64'({score, lives}), 64'({3'd0, 2'd3}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dups;
    int cnt;
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_in = 8'd0;
    guess_valid = 1'b0; guess = 8'd0;

    // Load 50..80 set and win with every guess correct.
    add(1,0,0, 0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,50,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,30,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,70,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,20,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,40,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,60,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,80,0,0,   3'd2,0,0,0, 3'd0,2'd3,0);
    add(0,0,0, 0,0,   3'd3,0,0,0, 3'd0,2'd3,1);
    add(0,0,0, 1,50,  3'd3,1,0,0, 3'd1,2'd3,1);
    add(0,0,0, 1,30,  3'd3,1,0,0, 3'd2,2'd3,1);
    add(0,0,0, 1,70,  3'd3,1,0,0, 3'd3,2'd3,1);
    add(0,0,0, 1,20,  3'd3,1,0,0, 3'd4,2'd3,1);
    add(0,0,0, 1,40,  3'd3,1,0,0, 3'd5,2'd3,1);
    add(0,0,0, 1,60,  3'd3,1,0,0, 3'd6,2'd3,1);
    add(0,0,0, 1,80,  3'd4,1,0,0, 3'd7,2'd3,1);
    add(0,0,0, 0,0,   3'd4,0,0,0, 3'd7,2'd3,1);
    // Restart, load with a duplicate 10.
    add(1,0,0, 0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,10,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,10,0,0,   3'd1,0,0,1, 3'd0,2'd3,0);
    add(0,1,20,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,30,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,40,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,50,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,60,0,0,   3'd1,0,0,0, 3'd0,2'd3,0);
    add(0,1,70,0,0,   3'd2,0,0,0, 3'd0,2'd3,0);
    // Play: one hit (root 40), three misses to LOSE, then a guess in LOSE is ignored.
    add(0,0,0, 0,0,   3'd3,0,0,0, 3'd0,2'd3,1);
    add(0,0,0, 1,40,  3'd3,1,0,0, 3'd1,2'd3,1);
    add(0,0,0, 1,99,  3'd3,0,1,0, 3'd1,2'd2,1);
    add(0,0,0, 1,99,  3'd3,0,1,0, 3'd1,2'd1,1);
    add(0,0,0, 1,99,  3'd5,0,1,0, 3'd1,2'd0,1);
    add(0,0,0, 1,20,  3'd5,0,0,0, 3'd1,2'd0,1);

    step(); step();
    check_reset("reset");
    rst = 1'b0;

    run_vecs(0, 16);
    chk("win_flags", 64'({done, win}), 64'b11);
    chk("win_keys", 64'(keys_out), 64'h50_3C_28_14_46_1E_32);

    run_vecs(17, 25);
    chk("dup_keys", 64'(keys_out), 64'h46_3C_32_28_1E_14_0A);

    run_vecs(26, 31);
    chk("lose_flags", 64'({done, win}), 64'b10);

    // Timeout: key 0 first must not be flagged against cleared slots.
    load7({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, dups);
    chk("key0_no_dup", 64'(dups), 64'd0);
    chk("play_entry", 64'({state, core_valid}), 64'({3'd3, 1'b1}));
    cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (timeout || miss) cnt++;
    end
    chk("no_early_timeout", 64'(cnt), 64'd0);
    step();
    chk("timeout_pulse", 64'({timeout, miss, hit, lives}), 64'({1'b1, 1'b1, 1'b0, 2'd2}));
    cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (timeout || miss) cnt++;
    end
    chk("no_timeout_2", 64'(cnt), 64'd0);
    guess_valid = 1'b1; guess = 8'd3;
    step();
    guess_valid = 1'b0;
    chk("guess_at_expiry", 64'({hit, miss, timeout, score, lives}),
        64'({1'b1, 1'b0, 1'b0, 3'd1, 2'd2}));

    // Reach score 3, then start together with a correct guess.
    guess_valid = 1'b1; guess = 8'd1; step();
    guess = 8'd5; step();
    guess_valid = 1'b0;
    chk("score3", 64'({score, core_index}), 64'({3'd3, 3'd3}));
    start = 1'b1; guess_valid = 1'b1; guess = 8'd0;
    step();
    start = 1'b0; guess_valid = 1'b0;
    chk("restart_state", 64'({state, key_ready, hit, miss}), 64'({3'd1, 1'b1, 1'b0, 1'b0}));
    chk("restart_vals", 64'({score, lives, core_valid, core_index}), 64'({3'd0, 2'd3, 1'b0, 3'd0}));
    chk("restart_keys", 64'(keys_out), 64'd0);

    // Reset mid-LOAD.
    key_valid = 1'b1; key_in = 8'd9; step();
    key_in = 8'd8; step();
    chk("partial_load", 64'(keys_out), 64'h0809);
    rst = 1'b1; key_in = 8'd7; step();
    rst = 1'b0; key_valid = 1'b0;
    check_reset("rst_load");
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      guess_valid = 1'b1; guess = 8'(c);
      step();
      if (hit || miss || state != 3'd0) cnt++;
    end
    guess_valid = 1'b0;
    chk("idle_guess_ignored", 64'(cnt), 64'd0);

    // Reset in WIN.
    load7({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, dups);
    guess_valid = 1'b1;
    guess = 8'd3; step();
    guess = 8'd1; step();
    guess = 8'd5; step();
    guess = 8'd0; step();
    guess = 8'd2; step();
    guess = 8'd4; step();
    guess = 8'd6; step();
    guess_valid = 1'b0;
    chk("win2", 64'({state, win, score}), 64'({3'd4, 1'b1, 3'd7}));
    rst = 1'b1; step(); rst = 1'b0;
    check_reset("rst_win");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bst_game_ctrl.md
# bst_game_ctrl

Sequencer for the BST mini-game. It collects seven unique 8-bit keys from the player-input path and presents them, packed, to the BST sort/lookup core. It then walks the core's node index in level order (root, L, R, LL, LR, RL, RR) and checks each player guess against the core's node key. It tracks score, lives and a per-guess timeout, and reports win/lose to the display layer.

## Interface
Parameters:
- LIVES, 3: misses allowed before LOSE (1..3; `lives` is 2 bits).
- TIMEOUT_CYC, 50_000_000: cycles allowed per guess (≥2; override small in simulation).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins or restarts a game.
- key_in  in  8  key offered during load.
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  controller accepts a key this cycle.
- dup_err  out  1  one-cycle pulse; the offered key duplicated a stored key and was rejected.
- keys_out  out  56  packed stored keys {k6,k5,k4,k3,k2,k1,k0}; k0 is the first key accepted. Drives the core's seven key inputs.
- core_valid  out  1  core output enable.
- core_index  out  3  node index to core (0=root … 6=RR).
- core_key  in  8  node key returned combinationally by the core for core_index.
- guess  in  8  player guess.
- guess_valid  in  1  single-cycle pulse; guess is valid.
- hit, miss, timeout  out  1 each  one-cycle result pulses.
- score  out  3  nodes correctly guessed (0..7).
- lives  out  2  remaining lives.
- state  out  3  IDLE=0, LOAD=1, SETTLE=2, PLAY=3, WIN=4, LOSE=5.
- done  out  1  high in WIN or LOSE.
- win  out  1  high in WIN.

## Operation
- States:
  - IDLE: `start` → LOAD.
  - LOAD: `key_ready`=1. A handshake is `key_valid & key_ready`.
    - If key_in equals any already-stored key: `dup_err` pulses, nothing is stored, and the load count does not advance.
    - Otherwise key_in is stored in slot `load_cnt` and `load_cnt` increments.
    - Accepting the 7th unique key → SETTLE.
  - SETTLE: exactly one cycle; `core_valid` rises at its end → PLAY.
  - PLAY: `core_valid`=1, `core_index`=score.
    - guess_valid with guess==core_key: `hit` pulses and score increments. If score reaches 7 → WIN.
    - guess_valid with a mismatch: `miss` pulses and lives decrements. If lives reaches 0 → LOSE.
    - No guess for TIMEOUT_CYC cycles: `timeout` and `miss` pulse together and lives decrements. If lives reaches 0 → LOSE.
  - WIN / LOSE: hold all outputs (`core_valid` stays 1 so the display can read the tree). `start` → LOAD.
- Entering LOAD from any state:
  - clears all slots to 0 and sets `load_cnt`=0;
  - sets score=0, lives=LIVES, `core_valid`=0, `core_index`=0;
  - clears the timer.
- `start` is honoured in every state, including mid-LOAD and mid-PLAY, and restarts the game.
- A `start` in the same cycle as a handshake or guess takes priority; the key or guess is ignored.
- Timer runs only in PLAY. It clears on entry to PLAY and on every guess_valid.
  - Expiry is the cycle the timer equals TIMEOUT_CYC-1 with no guess_valid.
  - If guess_valid arrives in the expiry cycle, the guess is evaluated and no timeout occurs.
- guess_valid outside PLAY is ignored.
- Comparisons are unsigned 8-bit equality. Key value 0 is legal.
- The duplicate check covers only the `load_cnt` slots filled so far, not cleared slots.

## Timing
- Reset values:
  - state=IDLE, keys_out=0, key_ready=0, dup_err=0;
  - core_valid=0, core_index=0;
  - hit=miss=timeout=0, score=0, lives=LIVES;
  - done=0, win=0.
- All outputs are registered except `key_ready` and `done`/`win`, which decode directly from state.
- Result pulses, score and lives update the cycle after guess_valid, which is also when the state change occurs.
- A hit advances `core_index` one cycle after the guess, so the next guess may arrive the following cycle.
- Load latency: the 7th accept edge → SETTLE. `core_valid`=1 from the next edge, and PLAY accepts a guess that cycle.
- Throughput: one key per cycle in LOAD; one guess per cycle in PLAY.

## Test plan
- Load 50,30,70,20,40,60,80 back-to-back; guess 50,30,70,20,40,60,80 → 7 hit pulses, score 0→7, state WIN, win=1, lives=3.
- Load 10,10,20,… → dup_err pulses on the second 10 and load_cnt stays at 1. Completing the load with 30..70 gives keys_out k1=20.
- Load the first set; guesses 50,99,99,99 → hit, then three misses; lives 3→0, state LOSE, done=1, win=0, score=1.
- TIMEOUT_CYC=8; enter PLAY and idle → timeout+miss at cycle 8, lives=2. A guess issued exactly in the expiry cycle produces no timeout.
- Assert start mid-PLAY with score=3 → next cycle state LOAD, score=0, lives=3, core_valid=0, keys_out=0.
- Assert rst in the middle of LOAD and in WIN → all outputs return to their reset values on the next edge; guess_valid pulses in IDLE produce no hit or miss.
